// File: rtl/liteic_slave_node_read_if.sv
// Crossbar-side request/response bundle plus the AXI-Lite AR/R channels of one slave slot.
// Pure wiring; no state or latency of its own.
// Backpressure is carried by the rdy/ready signals in both directions.
interface liteic_slave_node_read_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int RDATA_WIDTH = 34
);
  logic [NUM_MASTERS-1:0] cbar_reqst_val_i;
  logic [ADDR_WIDTH-1:0]  cbar_reqst_data_i [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] cbar_reqst_rdy_o;
  logic [RDATA_WIDTH-1:0] cbar_resp_data_o;
  logic [NUM_MASTERS-1:0] cbar_resp_val_o;
  logic [NUM_MASTERS-1:0] cbar_resp_rdy_i;
  logic                   slv_ar_valid_o;
  logic [ADDR_WIDTH-1:0]  slv_ar_addr_o;
  logic                   slv_ar_ready_i;
  logic                   slv_r_valid_i;
  logic [RDATA_WIDTH-1:0] slv_r_data_i;
  logic                   slv_r_ready_o;

  // The read node itself.
  modport slave (
    input  cbar_reqst_val_i, cbar_reqst_data_i, cbar_resp_rdy_i,
    input  slv_ar_ready_i, slv_r_valid_i, slv_r_data_i,
    output cbar_reqst_rdy_o, cbar_resp_data_o, cbar_resp_val_o,
    output slv_ar_valid_o, slv_ar_addr_o, slv_r_ready_o
  );

  // Whatever drives the node: crossbar masters and the AXI-Lite slave.
  modport master (
    output cbar_reqst_val_i, cbar_reqst_data_i, cbar_resp_rdy_i,
    output slv_ar_ready_i, slv_r_valid_i, slv_r_data_i,
    input  cbar_reqst_rdy_o, cbar_resp_data_o, cbar_resp_val_o,
    input  slv_ar_valid_o, slv_ar_addr_o, slv_r_ready_o
  );
endinterface

// File: rtl/liteic_slave_node_read.sv
// Read-side slave node: round-robin picks one master, issues its AR, forwards the R beat back.
// Grant to AR valid is 1 cycle; R is passed combinationally; min 3 cycles per read.
// One read outstanding; other requesters stall; R ready follows the granted master's resp_rdy.
module liteic_slave_node_read #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int RDATA_WIDTH = 34
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  liteic_slave_node_read_if.slave     bus
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          last_grant_q;
  logic [IW-1:0]          grant_q;
  logic [IW-1:0]          sel;
  logic                   any_req;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   ar_valid_q;
  logic [NUM_MASTERS-1:0] reqst_rdy;
  logic [NUM_MASTERS-1:0] resp_val;
  logic [RDATA_WIDTH-1:0] resp_data;
  logic                   r_ready;
  int unsigned            idx;

  // Round-robin search starting just after the previous winner; first set bit wins.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(last_grant_q) + 1 + i) % NUM_MASTERS;
      if (!any_req && bus.cbar_reqst_val_i[IW'(idx)]) begin
        any_req = 1'b1;
        sel     = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant, captured address and AR valid; last_grant resets so master 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= IW'(NUM_MASTERS - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      ar_valid_q   <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      last_grant_q <= sel;
      grant_q      <= sel;
      addr_q       <= bus.cbar_reqst_data_i[sel];
      ar_valid_q   <= 1'b1;
    end else if (state_q == ADDR && bus.slv_ar_ready_i) begin
      ar_valid_q   <= 1'b0;
    end
  end

  // Next state and the combinational handshake outputs; rdy is masked while reset is held.
  always_comb begin
    state_d   = state_q;
    reqst_rdy = '0;
    resp_val  = '0;
    resp_data = '0;
    r_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d        = ADDR;
          reqst_rdy[sel] = ~rst_i;
        end
      end
      ADDR: begin
        if (bus.slv_ar_ready_i) state_d = RESP;
      end
      RESP: begin
        resp_val[grant_q] = bus.slv_r_valid_i;
        resp_data         = bus.slv_r_data_i;
        r_ready           = bus.cbar_resp_rdy_i[grant_q];
        if (bus.slv_r_valid_i && bus.cbar_resp_rdy_i[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cbar_reqst_rdy_o = reqst_rdy;
  assign bus.cbar_resp_val_o  = resp_val;
  assign bus.cbar_resp_data_o = resp_data;
  assign bus.slv_r_ready_o    = r_ready;
  assign bus.slv_ar_valid_o   = ar_valid_q;
  assign bus.slv_ar_addr_o    = addr_q;

endmodule

// File: doc/liteic_slave_node_read.md
LITEIC_SLAVE_NODE_READ -- requirements
Module: liteic_slave_node_read

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of master nodes that can reach this slave slot.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: crossbar request address width (region offset bits).
REQ-003 SHALL have parameter RDATA_WIDTH, default 34: response word, {r_data[31:0], r_resp[1:0]}.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cbar_reqst_val_i, input, NUM_MASTERS: per-master read request valid.
REQ-007 SHALL have port cbar_reqst_data_i, input, NUM_MASTERS x ADDR_WIDTH (unpacked array): per-master request address.
REQ-008 SHALL have port cbar_reqst_rdy_o, output, NUM_MASTERS: per-master request accept.
REQ-009 SHALL have port cbar_resp_data_o, output, RDATA_WIDTH: response word, common to all masters.
REQ-010 SHALL have port cbar_resp_val_o, output, NUM_MASTERS: per-master response valid.
REQ-011 SHALL have port cbar_resp_rdy_i, input, NUM_MASTERS: per-master response ready.
REQ-012 SHALL have ports slv_ar_valid_o (out, 1), slv_ar_addr_o (out, ADDR_WIDTH), slv_ar_ready_i (in, 1): AXI-Lite AR channel to the slave.
REQ-013 SHALL have ports slv_r_valid_i (in, 1), slv_r_data_i (in, RDATA_WIDTH), slv_r_ready_o (out, 1): AXI-Lite R channel from the slave.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, RESP; reset state IDLE.
REQ-015 SHALL, in IDLE with any cbar_reqst_val_i bit set, select one master round-robin: search starts at (last_grant+1) mod NUM_MASTERS, wraps, first set bit wins.
REQ-016 SHALL, on that selection cycle, assert cbar_reqst_rdy_o[grant] for exactly one cycle (all other bits 0), register grant index and cbar_reqst_data_i[grant], update last_grant, and enter ADDR.
REQ-017 SHALL keep cbar_reqst_rdy_o all-zero outside the selection cycle; requests from other masters stall until the node returns to IDLE.
REQ-018 SHALL, in ADDR, drive slv_ar_valid_o=1 and slv_ar_addr_o from the register (both register outputs), held stable until slv_ar_ready_i=1; then go to RESP.
REQ-019 SHALL, in ADDR, move to RESP on the first cycle with slv_ar_ready_i=1; slv_ar_valid_o drops the following cycle.
REQ-020 SHALL, in RESP, combinationally drive cbar_resp_val_o[grant]=slv_r_valid_i (others 0), cbar_resp_data_o=slv_r_data_i, and slv_r_ready_o=cbar_resp_rdy_i[grant].
REQ-021 SHALL return to IDLE on the cycle slv_r_valid_i && cbar_resp_rdy_i[grant]; a new grant is possible on the next cycle (minimum three cycles per transaction).
REQ-022 SHALL drive slv_r_ready_o=0, cbar_resp_val_o=0 outside RESP; slave R beats outside RESP are ignored.
REQ-023 SHALL drive cbar_resp_data_o=0 outside RESP.
REQ-024 SHALL allow at most one outstanding read; a single requester is always granted regardless of last_grant.
REQ-025 SHALL pass cbar_resp_data_o unmodified; the resp field (including SLVERR/DECERR) is not interpreted.

Reset
REQ-026 SHALL, while rst_i=1, immediately force state IDLE, last_grant=NUM_MASTERS-1, grant=0, address register=0, and all outputs 0.
REQ-027 SHALL, on reset asserted mid-transaction (ADDR or RESP), abandon the transaction without a response; the first grant after release goes to master 0 if requesting.

Verification
REQ-028 SHALL pass: single read by master 2 at addr 0x3C, slave ar_ready after 2 cycles, r_data=0xDEADBEEF resp=OKAY -> master 2 sees one resp_val beat with data {0xDEADBEEF,2'b00}; rdy_o[2] pulses once.
REQ-029 SHALL pass: masters 0-3 request continuously after reset -> grant order 0,1,2,3,0; each AR addr matches its master.
REQ-030 SHALL pass: master 1 holds resp_rdy=0 for 5 cycles with slv_r_valid=1 -> slv_r_ready_o=0 for those 5 cycles, data stable, completion on the 6th.
REQ-031 SHALL pass: slave returns resp=2'b10 -> word forwarded unchanged to the granted master only.
REQ-032 SHALL pass: rst_i pulsed during RESP -> all outputs 0 asynchronously, state IDLE, next grant to master 0.
REQ-033 SHALL pass: master 3 drops then re-raises request while master 1 holds the node -> no rdy_o[3] pulse until IDLE, then master 3 is granted before master 0.
